// File: rtl/block_mm_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// block_mm_scheduler_pkg
// Shared definitions for the tiled matrix-multiply scheduler and the engines
// it sequences (tile loader, MAC array, store_block).
//   - default geometry (N, Tn), origin width, address-space limit
//   - sched_state_t: scheduler FSM encoding
//   - index slot numbering for the i/j/k tile counters
//   - idx_width(): counter width for NB tiles per dimension
// ---------------------------------------------------------------------------
package block_mm_scheduler_pkg;

    localparam int N_DEFAULT  = 16;
    localparam int TN_DEFAULT = 4;
    localparam int ORIG_W     = 8;     // tile origins live in an 8-bit address space
    localparam int ADDR_SPACE = 256;

    // Slot numbers of the three tile indices in the counter arrays
    localparam int IDX_I  = 0;
    localparam int IDX_J  = 1;
    localparam int IDX_K  = 2;
    localparam int NUM_IDX = 3;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        MAC_REQ,
        MAC_WAIT,
        ST_REQ,
        ST_WAIT,
        FIN
    } sched_state_t;

    // Width of a tile index counter; never zero so NB == 1 still elaborates.
    function automatic int idx_width(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/block_mm_scheduler_if.sv
// ---------------------------------------------------------------------------
// block_mm_scheduler_if
// Control bundle between the scheduler and its environment.
//   start/busy/done          : run request and status
//   ld_*                     : tile loader strobe, A/B tile origins, completion
//   mac_start/acc_clr/mac_done: MAC array strobe, overwrite flag, completion
//   st_*                     : store_block strobe, C tile origin, completion
// master: the scheduler side.  slave: the engines / host side.
// ---------------------------------------------------------------------------
interface block_mm_scheduler_if;
    import block_mm_scheduler_pkg::*;

    logic              start;
    logic              busy;
    logic              done;

    logic              ld_start;
    logic [ORIG_W-1:0] ld_a_row;
    logic [ORIG_W-1:0] ld_a_col;
    logic [ORIG_W-1:0] ld_b_row;
    logic [ORIG_W-1:0] ld_b_col;
    logic              ld_done;

    logic              mac_start;
    logic              acc_clr;
    logic              mac_done;

    logic              st_start;
    logic [ORIG_W-1:0] st_row;
    logic [ORIG_W-1:0] st_col;
    logic              st_done;

    modport master (
        input  start, ld_done, mac_done, st_done,
        output busy, done,
        output ld_start, ld_a_row, ld_a_col, ld_b_row, ld_b_col,
        output mac_start, acc_clr,
        output st_start, st_row, st_col
    );

    modport slave (
        output start, ld_done, mac_done, st_done,
        input  busy, done,
        input  ld_start, ld_a_row, ld_a_col, ld_b_row, ld_b_col,
        input  mac_start, acc_clr,
        input  st_start, st_row, st_col
    );

endinterface

// File: rtl/block_mm_scheduler_tile_index_counter.sv
// ---------------------------------------------------------------------------
// block_mm_scheduler_tile_index_counter
// Nested tile indices: k innermost, then j, then i (row-major C tiles).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : zero all indices (start of a run)
//   inc_k_i    : advance k (caller guarantees k is not last)
//   inc_ij_i   : C tile finished: k=0 and advance j, carrying into i;
//                wraps to (0,0) after the final tile
//   idx_o[3]   : current i/j/k (slots IDX_I/IDX_J/IDX_K)
//   last_o[3]  : index equals NB-1
// clr_i has priority over inc_ij_i, which has priority over inc_k_i.
// ---------------------------------------------------------------------------
module block_mm_scheduler_tile_index_counter
    import block_mm_scheduler_pkg::*;
#(
    parameter int NB    = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_k_i,
    input  logic             inc_ij_i,
    output logic [IDX_W-1:0] idx_o  [NUM_IDX],
    output logic [NUM_IDX-1:0] last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic [IDX_W-1:0] idx_q [NUM_IDX];
    logic [IDX_W-1:0] idx_d [NUM_IDX];
    logic [NUM_IDX-1:0] last;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDX; gi++) begin : g_idx
            assign last[gi]  = (idx_q[gi] == LAST_IDX);
            assign idx_o[gi] = idx_q[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    idx_q[gi] <= '0;
                end else begin
                    idx_q[gi] <= idx_d[gi];
                end
            end
        end
    endgenerate

    assign last_o = last;

    always_comb begin
        idx_d[IDX_I] = idx_q[IDX_I];
        idx_d[IDX_J] = idx_q[IDX_J];
        idx_d[IDX_K] = idx_q[IDX_K];
        if (clr_i) begin
            idx_d[IDX_I] = '0;
            idx_d[IDX_J] = '0;
            idx_d[IDX_K] = '0;
        end else if (inc_ij_i) begin
            idx_d[IDX_K] = '0;
            if (last[IDX_J]) begin
                idx_d[IDX_J] = '0;
                idx_d[IDX_I] = last[IDX_I] ? '0 : idx_q[IDX_I] + 1'b1;
            end else begin
                idx_d[IDX_J] = idx_q[IDX_J] + 1'b1;
            end
        end else if (inc_k_i) begin
            idx_d[IDX_K] = idx_q[IDX_K] + 1'b1;
        end
    end

endmodule

// File: rtl/block_mm_scheduler.sv
// ---------------------------------------------------------------------------
// block_mm_scheduler
// Sequencer for tiled C = A x B on N x N matrices with Tn x Tn tiles.
// For every C tile (i,j) and every k it requests a load of A(i,k)/B(k,j) and
// a MAC pass (acc_clr on k==0), then stores C(i,j). Owns no datapath.
// Ports:
//   clk      : clock, all state on posedge
//   rst      : asynchronous active-high reset
//   sched_if : block_mm_scheduler_if.master (handshakes, origins, status)
// Strobes are registered one-cycle pulses; origins are index*Tn decoded from
// the registered tile indices, so they hold from a REQ through its WAIT exit.
// ---------------------------------------------------------------------------
module block_mm_scheduler
    import block_mm_scheduler_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int Tn = TN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    block_mm_scheduler_if.master   sched_if
);

    localparam int NB    = N / Tn;
    localparam int IDX_W = idx_width(NB);
    localparam logic [ORIG_W-1:0] TN_O = ORIG_W'(Tn);

    generate
        if (N % Tn != 0) begin : g_bad_tile
            $error("block_mm_scheduler: N must be a multiple of Tn");
        end
        if (N * N > ADDR_SPACE) begin : g_bad_size
            $error("block_mm_scheduler: N*N exceeds the 8-bit address space");
        end
    endgenerate

    sched_state_t       state_q;
    logic               ld_start_q;
    logic               mac_start_q;
    logic               acc_clr_q;
    logic               st_start_q;
    logic               busy_q;
    logic               done_q;

    logic [IDX_W-1:0]   idx [NUM_IDX];
    logic [NUM_IDX-1:0] last;
    logic [ORIG_W-1:0]  orig [NUM_IDX];
    logic               clr_idx;
    logic               inc_k;
    logic               inc_ij;

    // Index updates happen on the same edge the FSM leaves a WAIT state,
    // so the next REQ already sees the new indices.
    assign clr_idx = (state_q == IDLE)     && sched_if.start;
    assign inc_k   = (state_q == MAC_WAIT) && sched_if.mac_done && !last[IDX_K];
    assign inc_ij  = (state_q == ST_WAIT)  && sched_if.st_done;

    block_mm_scheduler_tile_index_counter #(
        .NB    (NB),
        .IDX_W (IDX_W)
    ) u_tile_index_counter (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr_idx),
        .inc_k_i  (inc_k),
        .inc_ij_i (inc_ij),
        .idx_o    (idx),
        .last_o   (last)
    );

    // (NB-1)*Tn <= N-Tn < 256, so the 8-bit product never wraps.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDX; gi++) begin : g_orig
            assign orig[gi] = ORIG_W'(idx[gi]) * TN_O;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_start_q  <= 1'b0;
            mac_start_q <= 1'b0;
            acc_clr_q   <= 1'b0;
            st_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Strobes default low: each is raised only on entry to its state.
            ld_start_q  <= 1'b0;
            mac_start_q <= 1'b0;
            acc_clr_q   <= 1'b0;
            st_start_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sched_if.start) begin
                        state_q    <= LD_REQ;
                        ld_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LD_REQ: begin
                    state_q <= LD_WAIT;
                end
                LD_WAIT: begin
                    if (sched_if.ld_done) begin
                        state_q     <= MAC_REQ;
                        mac_start_q <= 1'b1;
                        acc_clr_q   <= (idx[IDX_K] == '0);
                    end
                end
                MAC_REQ: begin
                    state_q <= MAC_WAIT;
                end
                MAC_WAIT: begin
                    if (sched_if.mac_done) begin
                        if (last[IDX_K]) begin
                            state_q    <= ST_REQ;
                            st_start_q <= 1'b1;
                        end else begin
                            state_q    <= LD_REQ;
                            ld_start_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sched_if.st_done) begin
                        if (last[IDX_I] && last[IDX_J]) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= LD_REQ;
                            ld_start_q <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sched_if.ld_start  = ld_start_q;
    assign sched_if.mac_start = mac_start_q;
    assign sched_if.acc_clr   = acc_clr_q;
    assign sched_if.st_start  = st_start_q;
    assign sched_if.busy      = busy_q;
    assign sched_if.done      = done_q;

    assign sched_if.ld_a_row  = orig[IDX_I];
    assign sched_if.ld_a_col  = orig[IDX_K];
    assign sched_if.ld_b_row  = orig[IDX_K];
    assign sched_if.ld_b_col  = orig[IDX_J];
    assign sched_if.st_row    = orig[IDX_I];
    assign sched_if.st_col    = orig[IDX_J];

endmodule

// File: tb/tb_block_mm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_block_mm_scheduler
// Directed bench: dut_a (N=16, Tn=4) and dut_b (N=8, Tn=4). Engine replies are
// modelled by a responder that pulses *_done three cycles after each strobe;
// a manual override drives dut_a's done inputs for cycle-exact steps.
// ---------------------------------------------------------------------------
module tb_block_mm_scheduler;
    import block_mm_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_mm_scheduler_if bus_a ();
    block_mm_scheduler_if bus_b ();

    block_mm_scheduler #(.N(16), .Tn(4)) dut_a (.clk(clk), .rst(rst), .sched_if(bus_a.master));
    block_mm_scheduler #(.N(8),  .Tn(4)) dut_b (.clk(clk), .rst(rst), .sched_if(bus_b.master));

    int checks = 0;
    int errors = 0;

    logic auto_en = 1'b0;
    logic man_ld_done = 1'b0;
    logic man_mac_done = 1'b0;
    logic man_st_done = 1'b0;
    logic auto_done [2][3];
    int   pend      [2][3];

    assign bus_a.ld_done  = auto_done[0][0] | man_ld_done;
    assign bus_a.mac_done = auto_done[0][1] | man_mac_done;
    assign bus_a.st_done  = auto_done[0][2] | man_st_done;
    assign bus_b.ld_done  = auto_done[1][0];
    assign bus_b.mac_done = auto_done[1][1];
    assign bus_b.st_done  = auto_done[1][2];

    // Engine model: reply 3 cycles after a strobe; cleared by rst like the engines.
    always @(negedge clk) begin
        logic [2:0] stb [2];
        stb[0] = {bus_a.st_start, bus_a.mac_start, bus_a.ld_start};
        stb[1] = {bus_b.st_start, bus_b.mac_start, bus_b.ld_start};
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 3; e++) begin
                auto_done[d][e] = 1'b0;
                if (rst) begin
                    pend[d][e] = 0;
                end else begin
                    if (pend[d][e] > 0) begin
                        pend[d][e]--;
                        if (pend[d][e] == 0) auto_done[d][e] = 1'b1;
                    end
                    if (stb[d][e] && auto_en) pend[d][e] = 3;
                end
            end
        end
    end

    // Transaction log
    int cnt_ld [2];
    int cnt_mac [2];
    int cnt_st [2];
    int cnt_done [2];
    int cnt_clr;
    logic [7:0] a_ld_acol [$];
    logic [7:0] a_ld_brow [$];
    logic       a_clr [$];
    logic [7:0] a_st_row [$];
    logic [7:0] a_st_col [$];
    logic [7:0] b_st_row [$];
    logic [7:0] b_st_col [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.ld_start) begin
                cnt_ld[0]++;
                a_ld_acol.push_back(bus_a.ld_a_col);
                a_ld_brow.push_back(bus_a.ld_b_row);
            end
            if (bus_a.mac_start) begin
                cnt_mac[0]++;
                a_clr.push_back(bus_a.acc_clr);
                if (bus_a.acc_clr) cnt_clr++;
            end
            if (bus_a.st_start) begin
                cnt_st[0]++;
                a_st_row.push_back(bus_a.st_row);
                a_st_col.push_back(bus_a.st_col);
            end
            if (bus_a.done) cnt_done[0]++;
            if (bus_b.ld_start)  cnt_ld[1]++;
            if (bus_b.mac_start) cnt_mac[1]++;
            if (bus_b.st_start) begin
                cnt_st[1]++;
                b_st_row.push_back(bus_b.st_row);
                b_st_col.push_back(bus_b.st_col);
            end
            if (bus_b.done) cnt_done[1]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            cnt_ld[d] = 0; cnt_mac[d] = 0; cnt_st[d] = 0; cnt_done[d] = 0;
        end
        cnt_clr = 0;
        a_ld_acol = {}; a_ld_brow = {}; a_clr = {};
        a_st_row = {}; a_st_col = {}; b_st_row = {}; b_st_col = {};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for dut_a done; optional start pulse mid-run to test drop.
    task automatic wait_done_a(input bit poke_start, output bit got);
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (poke_start && c == 40) bus_a.start = 1'b1;
            if (c == 41) bus_a.start = 1'b0;
            if (bus_a.done) begin
                got = 1'b1;
                break;
            end
        end
        bus_a.start = 1'b0;
    endtask

    bit got;

    initial begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        clear_logs();

        // ---- Reset state ----
        repeat (3) step();
        check("rst_busy",      bus_a.busy, 0);
        check("rst_done",      bus_a.done, 0);
        check("rst_ld_start",  bus_a.ld_start, 0);
        check("rst_mac_start", bus_a.mac_start, 0);
        check("rst_st_start",  bus_a.st_start, 0);
        check("rst_ld_a_row",  bus_a.ld_a_row, 0);
        check("rst_st_col",    bus_a.st_col, 0);
        check("rst_b_busy",    bus_b.busy, 0);
        rst = 1'b0;
        step();

        // ---- st_done in IDLE is ignored ----
        man_st_done = 1'b1; step(); man_st_done = 1'b0;
        check("idle_st_done_busy",  bus_a.busy, 0);
        check("idle_st_done_st",    bus_a.st_start, 0);
        $display("txn: spurious st_done in IDLE");

        // ---- Start latency ----
        bus_a.start = 1'b1; step(); bus_a.start = 1'b0;
        check("lat_ld_start_hi", bus_a.ld_start, 1);
        check("lat_busy",        bus_a.busy, 1);
        // ld_done coincident with LD_REQ: ignored
        man_ld_done = 1'b1; step(); man_ld_done = 1'b0;
        check("lat_ld_start_lo", bus_a.ld_start, 0);
        check("coinc_ld_done",   bus_a.mac_start, 0);
        // mac_done while in LD_WAIT: ignored
        man_mac_done = 1'b1; step(); man_mac_done = 1'b0;
        check("spur_mac_done_mac", bus_a.mac_start, 0);
        check("spur_mac_done_ld",  bus_a.ld_start, 0);
        step();
        check("still_ld_wait", bus_a.mac_start, 0);
        $display("txn: start accepted, coincident/spurious dones ignored");
        // ld_done in LD_WAIT -> mac_start next cycle, acc_clr for k=0
        man_ld_done = 1'b1; step(); man_ld_done = 1'b0;
        check("lat_mac_start_hi", bus_a.mac_start, 1);
        check("acc_clr_k0",       bus_a.acc_clr, 1);
        step();
        check("lat_mac_start_lo", bus_a.mac_start, 0);
        // mac_done with k=0 -> load k=1
        man_mac_done = 1'b1; step(); man_mac_done = 1'b0;
        check("k1_ld_start", bus_a.ld_start, 1);
        check("k1_ld_a_col", bus_a.ld_a_col, 4);
        check("k1_ld_b_row", bus_a.ld_b_row, 4);
        check("k1_ld_a_row", bus_a.ld_a_row, 0);
        check("k1_ld_b_col", bus_a.ld_b_col, 0);
        step();
        man_ld_done = 1'b1; step(); man_ld_done = 1'b0;
        check("k1_mac_start", bus_a.mac_start, 1);
        check("k1_acc_clr",   bus_a.acc_clr, 0);
        $display("txn: manual k=0,k=1 passes");
        rst = 1'b1; #1;
        check("abort_busy",     bus_a.busy, 0);
        check("abort_mac",      bus_a.mac_start, 0);
        check("abort_ld_a_col", bus_a.ld_a_col, 0);
        step(); rst = 1'b0; step();

        // ---- Full run with engines, start re-pulsed while busy ----
        auto_en = 1'b1;
        clear_logs();
        bus_a.start = 1'b1; step(); bus_a.start = 1'b0;
        wait_done_a(1'b1, got);
        check("run1_done_seen", got, 1);
        repeat (10) step();
        check("run1_ld",    cnt_ld[0], 64);
        check("run1_mac",   cnt_mac[0], 64);
        check("run1_st",    cnt_st[0], 16);
        check("run1_done",  cnt_done[0], 1);
        check("run1_clr",   cnt_clr, 16);
        check("run1_busy",  bus_a.busy, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("run1_ld%0d_a_col", k), a_ld_acol[k], 4 * k);
            check($sformatf("run1_ld%0d_b_row", k), a_ld_brow[k], 4 * k);
        end
        check("run1_clr0", a_clr[0], 1);
        check("run1_clr1", a_clr[1], 0);
        check("run1_clr4", a_clr[4], 1);
        check("run1_st0_row",  a_st_row[0], 0);
        check("run1_st0_col",  a_st_col[0], 0);
        check("run1_st1_row",  a_st_row[1], 0);
        check("run1_st1_col",  a_st_col[1], 4);
        check("run1_st15_row", a_st_row[15], 12);
        check("run1_st15_col", a_st_col[15], 12);
        $display("txn: full run ld=%0d mac=%0d st=%0d done=%0d", cnt_ld[0], cnt_mac[0], cnt_st[0], cnt_done[0]);

        // ---- Reset during 5th MAC_WAIT ----
        clear_logs();
        bus_a.start = 1'b1; step(); bus_a.start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk); #1;
            if (cnt_mac[0] >= 5) begin
                got = 1'b1;
                break;
            end
        end
        check("mid_reached_mac5", got, 1);
        step();
        check("mid_pre_b_col", bus_a.ld_b_col, 4);
        rst = 1'b1; #1;
        check("mid_busy",   bus_a.busy, 0);
        check("mid_ld",     bus_a.ld_start, 0);
        check("mid_mac",    bus_a.mac_start, 0);
        check("mid_st",     bus_a.st_start, 0);
        check("mid_done",   bus_a.done, 0);
        check("mid_b_col",  bus_a.ld_b_col, 0);
        step(); rst = 1'b0; step();
        $display("txn: reset in 5th MAC_WAIT");
        clear_logs();
        bus_a.start = 1'b1; step(); bus_a.start = 1'b0;
        wait_done_a(1'b0, got);
        check("run2_done_seen", got, 1);
        repeat (10) step();
        check("run2_ld",   cnt_ld[0], 64);
        check("run2_mac",  cnt_mac[0], 64);
        check("run2_st",   cnt_st[0], 16);
        check("run2_done", cnt_done[0], 1);
        check("run2_ld0_a_col", a_ld_acol[0], 0);
        check("run2_st0_col",   a_st_col[0], 0);
        $display("txn: rerun after reset ld=%0d mac=%0d st=%0d", cnt_ld[0], cnt_mac[0], cnt_st[0]);

        // ---- Small configuration N=8, Tn=4 ----
        clear_logs();
        bus_b.start = 1'b1; step(); bus_b.start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus_b.done) begin
                got = 1'b1;
                break;
            end
        end
        check("small_done_seen", got, 1);
        repeat (10) step();
        check("small_ld",   cnt_ld[1], 8);
        check("small_mac",  cnt_mac[1], 8);
        check("small_st",   cnt_st[1], 4);
        check("small_done", cnt_done[1], 1);
        for (int t = 0; t < 4; t++) begin
            check($sformatf("small_st%0d_row", t), b_st_row[t], (t / 2) * 4);
            check($sformatf("small_st%0d_col", t), b_st_col[t], (t % 2) * 4);
        end
        $display("txn: small config ld=%0d mac=%0d st=%0d", cnt_ld[1], cnt_mac[1], cnt_st[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
